// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiter: state encoding, default character
// format and the index-width helper.
package uart_arb_pkg;

  localparam logic ST_IDLE   = 1'b0;
  localparam logic ST_LOCKED = 1'b1;

  typedef enum logic {
    StIdle   = ST_IDLE,
    StLocked = ST_LOCKED
  } state_e;

  localparam int unsigned     DEF_W        = 7;
  localparam logic [DEF_W-1:0] DEF_EOL_CODE = 7'h0A;

  // Bits needed to index n items; never less than one.
  function automatic int unsigned idx_width(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first valid index after ptr, wrapping modulo N.
module uart_rr_pick
  import uart_arb_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = idx_width(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [PW-1:0] ptr,
  output logic          any,
  output logic [PW-1:0] winner
);

  logic [PW-1:0] idx;

  // Scan from farthest to nearest so the nearest valid index is assigned last.
  always_comb begin
    any    = |valid;
    winner = '0;
    idx    = '0;
    for (int k = int'(N); k >= 1; k--) begin
      idx = PW'((int'(ptr) + k) % int'(N));
      if (valid[idx]) winner = idx;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, line-locking arbiter in front of one UartTX with a one-entry holding register.
// Optional forced release of an idle line owner: define UART_ARB_IDLE_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned   N        = 4,
  parameter int unsigned   W        = DEF_W,
  parameter logic [W-1:0]  EOL_CODE = W'(DEF_EOL_CODE)
`ifdef UART_ARB_IDLE_TIMEOUT_EN
  ,
  parameter int unsigned   TIMEOUT  = 1024
`endif
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req_valid,
  input  logic [N*W-1:0] req_data,
  output logic [N-1:0]   req_ack,
  output logic [N-1:0]   grant,
  output logic           busy,
  output logic           tx_load,
  output logic [W-1:0]   tx_data,
  input  logic           tx_ready
);

  localparam int unsigned PW = idx_width(N);

  state_e        state_q;
  logic [PW-1:0] ptr_q, g_q;
  logic [N-1:0]  grant_q;
  logic          hold_valid_q;
  logic [W-1:0]  hold_data_q;

`ifdef UART_ARB_IDLE_TIMEOUT_EN
  localparam int unsigned CW = idx_width(TIMEOUT);
  logic [CW-1:0] idle_cnt_q;
`endif

  logic          pick_any;
  logic [PW-1:0] pick_idx;
  logic          owner_valid;
  logic [W-1:0]  owner_data;
  logic          accept;

  uart_rr_pick #(
    .N  (N),
    .PW (PW)
  ) u_pick (
    .valid  (req_valid),
    .ptr    (ptr_q),
    .any    (pick_any),
    .winner (pick_idx)
  );

  always_comb begin
    owner_valid = 1'b0;
    owner_data  = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (g_q == PW'(i)) begin
        owner_valid = req_valid[i];
        owner_data  = req_data[i*W +: W];
      end
    end
  end

  // The hold drains in the same cycle it refills, so a full hold accepts when tx_ready is high.
  assign accept  = (state_q == StLocked) & owner_valid & (~hold_valid_q | tx_ready);
  assign req_ack = accept ? grant_q : '0;
  assign grant   = grant_q;
  assign busy    = (state_q == StLocked) | hold_valid_q;
  assign tx_load = hold_valid_q;
  assign tx_data = hold_data_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      ptr_q        <= PW'(N - 1);
      g_q          <= '0;
      grant_q      <= '0;
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
`ifdef UART_ARB_IDLE_TIMEOUT_EN
      idle_cnt_q   <= '0;
`endif
    end else begin
      if (accept) begin
        hold_valid_q <= 1'b1;
        hold_data_q  <= owner_data;
      end else if (hold_valid_q && tx_ready) begin
        hold_valid_q <= 1'b0;
      end

      case (state_q)
        StIdle: begin
          if (pick_any) begin
            state_q <= StLocked;
            g_q     <= pick_idx;
            ptr_q   <= pick_idx;
            grant_q <= {{(N-1){1'b0}}, 1'b1} << pick_idx;
`ifdef UART_ARB_IDLE_TIMEOUT_EN
            idle_cnt_q <= '0;
`endif
          end
        end
        StLocked: begin
          if (accept && owner_data == EOL_CODE) begin
            state_q <= StIdle;
            grant_q <= '0;
          end
`ifdef UART_ARB_IDLE_TIMEOUT_EN
          if (accept) begin
            idle_cnt_q <= '0;
          end else if (!owner_valid) begin
            if (idle_cnt_q == CW'(TIMEOUT - 1)) begin
              state_q <= StIdle;
              grant_q <= '0;
            end else begin
              idle_cnt_q <= idle_cnt_q + CW'(1);
            end
          end
`endif
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomised bench for uart_tx_arbiter against a cycle-level behavioural model of the
// arbitration rules, plus end-to-end line integrity checks on what a modelled UartTX received.
module tb_uart_tx_arbiter;

  localparam int N = 4;
  localparam int W = 7;
  localparam logic [W-1:0] EOL = 7'h0A;
`ifdef UART_ARB_IDLE_TIMEOUT_EN
  localparam int TIMEOUT = 16;
`endif

  typedef logic [W-1:0] ch_t;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid, req_ack, grant;
  logic [N*W-1:0] req_data;
  logic           busy, tx_load, tx_ready;
  logic [W-1:0]   tx_data;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .N        (N),
    .W        (W),
    .EOL_CODE (EOL)
`ifdef UART_ARB_IDLE_TIMEOUT_EN
    ,
    .TIMEOUT  (TIMEOUT)
`endif
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ack   (req_ack),
    .grant     (grant),
    .busy      (busy),
    .tx_load   (tx_load),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready)
  );

  ch_t src_q[N][$];
  ch_t sent_q[N][$];
  ch_t rx_src[N][$];
  ch_t rx_q[$];
  int  owners_q[$];
  int  ack_cnt[N];
  int  n_checks = 0;
  int  n_fail = 0;

  // Reference model state
  bit  m_locked;
  int  m_owner, m_ptr, m_idle;
  ch_t m_hold[$];

  int  uart_cnt;
  bit  stub;
  int  drop_pct;
  int  inter;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic ch_t enc(input int src, input int v);
    return ch_t'(32 + src * 16 + v);
  endfunction

  task automatic add_line(input int src, input int len);
    ch_t c;
    for (int j = 0; j < len; j++) begin
      c = enc(src, $urandom_range(0, 14));
      src_q[src].push_back(c);
      sent_q[src].push_back(c);
    end
    src_q[src].push_back(EOL);
    sent_q[src].push_back(EOL);
  endtask

  task automatic push_char(input int src, input ch_t c);
    src_q[src].push_back(c);
    sent_q[src].push_back(c);
  endtask

  task automatic clear_logs();
    rx_q.delete();
    for (int i = 0; i < N; i++) begin
      sent_q[i].delete();
      ack_cnt[i] = 0;
    end
  endtask

  task automatic model_reset();
    m_locked = 1'b0;
    m_owner  = 0;
    m_ptr    = N - 1;
    m_idle   = 0;
    m_hold.delete();
    uart_cnt = 0;
  endtask

  task automatic drive_inputs();
    bit en;
    for (int i = 0; i < N; i++) begin
      en = ($urandom_range(0, 99) >= drop_pct);
      req_valid[i] = (src_q[i].size() != 0) && en;
      req_data[i*W +: W] = (src_q[i].size() != 0) ? src_q[i][0] : ch_t'($urandom);
    end
    tx_ready = stub || (uart_cnt == 0);
  endtask

  // Compare DUT against the rules for this cycle, then advance the model to the next edge.
  task automatic model_cycle();
    bit          acc;
    ch_t         c;
    logic [31:0] exp_ack;
    acc = m_locked && req_valid[m_owner] && (m_hold.size() == 0 || tx_ready);
    c   = req_data[m_owner*W +: W];
    exp_ack = acc ? (32'd1 << m_owner) : 32'd0;
    check_eq("grant", grant, m_locked ? (32'd1 << m_owner) : 32'd0);
    check_eq("tx_load", tx_load, m_hold.size() != 0);
    if (m_hold.size() != 0) check_eq("tx_data", tx_data, m_hold[0]);
    check_eq("req_ack", req_ack, exp_ack);
    check_eq("busy", busy, m_locked || m_hold.size() != 0);

    if (m_hold.size() != 0 && tx_ready) void'(m_hold.pop_front());
    if (acc) m_hold.push_back(c);
    if (m_locked) begin
      if (acc) begin
        m_idle = 0;
        if (c == EOL) m_locked = 1'b0;
      end else if (!req_valid[m_owner]) begin
        m_idle++;
`ifdef UART_ARB_IDLE_TIMEOUT_EN
        if (m_idle == TIMEOUT) m_locked = 1'b0;
`endif
      end
    end else begin
      for (int k = 1; k <= N; k++) begin
        if (req_valid[(m_ptr + k) % N]) begin
          m_owner  = (m_ptr + k) % N;
          m_ptr    = m_owner;
          m_locked = 1'b1;
          m_idle   = 0;
          break;
        end
      end
    end
  endtask

  task automatic step();
    drive_inputs();
    @(negedge clk);
    model_cycle();
    for (int i = 0; i < N; i++) begin
      if (req_ack[i]) begin
        ack_cnt[i]++;
        if (src_q[i].size() != 0) void'(src_q[i].pop_front());
      end
    end
    if (tx_load && tx_ready) begin
      rx_q.push_back(tx_data);
      uart_cnt = stub ? 0 : $urandom_range(1, 4);
    end else if (uart_cnt > 0) begin
      uart_cnt--;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic int pending();
    int p;
    p = m_hold.size() + int'(m_locked);
    for (int i = 0; i < N; i++) p += src_q[i].size();
    return p;
  endfunction

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (pending() != 0 && n < budget) begin
      step();
      n++;
    end
    check_eq({tag, "_drained"}, pending(), 0);
  endtask

  // Split the received stream into lines, attributing each character to its encoded source.
  task automatic parse_rx(output int n_inter);
    int cur, s;
    n_inter = 0;
    cur = -1;
    owners_q.delete();
    for (int i = 0; i < N; i++) rx_src[i].delete();
    foreach (rx_q[k]) begin
      if (rx_q[k] == EOL) begin
        if (cur >= 0) rx_src[cur].push_back(rx_q[k]);
        owners_q.push_back(cur);
        cur = -1;
      end else begin
        s = (int'(rx_q[k]) - 32) / 16;
        if (s < 0 || s >= N) n_inter++;
        else begin
          if (cur < 0) cur = s;
          else if (s != cur) n_inter++;
          rx_src[s].push_back(rx_q[k]);
        end
      end
    end
  endtask

  task automatic check_streams(input string tag);
    int bad;
    for (int i = 0; i < N; i++) begin
      check_eq($sformatf("%s_len%0d", tag, i), rx_src[i].size(), sent_q[i].size());
      bad = 0;
      foreach (sent_q[i][k]) if (k >= rx_src[i].size() || rx_src[i][k] != sent_q[i][k]) bad++;
      check_eq($sformatf("%s_data%0d", tag, i), bad, 0);
    end
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    tx_ready  = 1'b1;
    stub      = 1'b0;
    drop_pct  = 0;
    model_reset();
    clear_logs();

    // Reset with req1/req2 pending; req1 sends "AB\n"
    push_char(1, 7'h41);
    push_char(1, 7'h42);
    push_char(1, EOL);
    push_char(2, 7'h43);
    push_char(2, EOL);
    drive_inputs();
    check_eq("reset_valid_in", req_valid, 4'b0110);
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_tx_load", tx_load, 0);
    check_eq("reset_grant", grant, 0);
    check_eq("reset_busy", busy, 0);
    reset = 1'b0;
    step();
    check_eq("first_grant", grant, 4'b0010);
    drain("line_ab", 200);
    check_eq("ab_rx_len", rx_q.size(), 5);
    check_eq("ab_c0", rx_q[0], 7'h41);
    check_eq("ab_c1", rx_q[1], 7'h42);
    check_eq("ab_c2", rx_q[2], 7'h0A);
    check_eq("ab_acks", ack_cnt[1], 3);

    // Two streaming requesters alternate by whole lines
    clear_logs();
    add_line(0, 2);
    add_line(0, 2);
    add_line(2, 2);
    add_line(2, 2);
    drain("alt", 500);
    parse_rx(inter);
    check_eq("alt_interleave", inter, 0);
    check_eq("alt_lines", owners_q.size(), 4);
    check_eq("alt_own0", owners_q[0], 0);
    check_eq("alt_own1", owners_q[1], 2);
    check_eq("alt_own2", owners_q[2], 0);
    check_eq("alt_own3", owners_q[3], 2);
    check_streams("alt");

    // Always-ready UartTX stub: one character per cycle
    clear_logs();
    stub = 1'b1;
    add_line(1, 20);
    drain("stub", 200);
    check_eq("stub_rx_len", rx_q.size(), 21);
    parse_rx(inter);
    check_streams("stub");
    stub = 1'b0;

    // Random lines from every requester with valid dropping mid-line
    clear_logs();
    drop_pct = 25;
    for (int i = 0; i < N; i++)
      for (int r = 0; r < 3; r++) add_line(i, $urandom_range(1, 4));
    drain("rand", 20000);
    drop_pct = 0;
    parse_rx(inter);
    check_eq("rand_interleave", inter, 0);
    check_streams("rand");

    // Asynchronous reset mid-line with the hold full
    clear_logs();
    add_line(2, 6);
    for (int k = 0; k < 50; k++) begin
      step();
      if (m_locked && m_hold.size() != 0) break;
    end
    check_eq("pre_reset_load", tx_load, 1);
    reset = 1'b1;
    #1;
    check_eq("async_tx_load", tx_load, 0);
    check_eq("async_grant", grant, 0);
    for (int i = 0; i < N; i++) src_q[i].delete();
    model_reset();
    for (int i = 0; i < N; i++) add_line(i, 1);
    drive_inputs();
    #1;
    check_eq("async_req_ack", req_ack, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step();
    check_eq("restart_idx0", grant, 4'b0001);
    drain("post_reset", 2000);

    // Owner req3 stalls after one character with req0 waiting
    clear_logs();
    push_char(3, enc(3, 8));
    step();
    step();
    check_eq("stall_grant", grant, 4'b1000);
    add_line(0, 2);
`ifdef UART_ARB_IDLE_TIMEOUT_EN
    repeat (60) step();
    check_eq("timeout_req0_sent", src_q[0].size(), 0);
    drain("timeout", 500);
`else
    repeat (5000) step();
    check_eq("lock_held", grant, 4'b1000);
    check_eq("req0_waiting", src_q[0].size(), 3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
